muxn_scan: RTL and testbench
============================

# muxn_scan

Parametrised N-channel, WIDTH-bit registered multiplexer and the successor to the 2:1 dataflow mux. Supports manual channel selection and an automatic scan mode, which steps through all channels with a programmable dwell time. Intended for time-multiplexed display and debug-probe paths. The output is registered, and a strobe flags every channel change.

## Interface
Parameters:
- WIDTH, 4, bits per channel (>=1)
- N, 4, channel count (2..16)
- DWELL, 4, cycles spent on each channel in scan mode (>=1)
- SELW, $clog2(N), width of sel/ch (derived; not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- d  in  N*WIDTH  packed inputs; channel i at d[i*WIDTH +: WIDTH]
- sel  in  SELW  manual channel select
- mode  in  1  0 = manual, 1 = scan
- en  in  1  clock enable; 0 freezes all state
- o  out  WIDTH  registered selected data
- ch  out  SELW  channel currently driving o
- ch_stb  out  1  one-cycle pulse: ch changed at the last edge

## Operation
- State: mode_q (MANUAL/SCAN), ch register, dwell counter cnt (0..DWELL-1), o register, ch_stb register.
- Reset (rst=1 at an edge, overrides en):
  - o=0, ch=0, cnt=0, ch_stb=0, mode_q=MANUAL.
- en=0:
  - All registers hold, except ch_stb, which is forced to 0.
  - o does not track d.
- en=1, MANUAL (mode=0):
  - ch_next = sel if sel < N; otherwise ch_next = ch (out-of-range select is ignored).
  - cnt <= 0.
- en=1, SCAN (mode=1):
  - If cnt == DWELL-1: ch_next = (ch == N-1) ? 0 : ch+1, and cnt <= 0.
  - Otherwise: ch_next = ch, and cnt <= cnt+1.
  - sel is ignored.
- Mode transitions, both taking effect at the first edge with en=1 and the new mode:
  - MANUAL->SCAN: cnt restarts at 0, scan begins from the current ch, and the first advance happens DWELL edges later.
  - SCAN->MANUAL: at that edge, ch_next follows the manual rule (sel), and cnt <= 0.
- Every en=1 edge:
  - ch <= ch_next.
  - o <= d[ch_next] (data sampled at that edge).
  - ch_stb <= (ch_next != ch).
  - mode_q <= mode.
- N not a power of 2: ch never holds a value >= N.

## Timing
- Latency: sel or d at edge k -> o/ch valid after edge k (1 cycle).
- ch_stb is high for exactly the cycle after the edge where ch changed, aligned with the new ch and o.
- Scan period: one channel per DWELL enabled cycles; full rotation = N*DWELL enabled cycles. With DWELL=1, ch advances every enabled edge and ch_stb stays high continuously.
- Disabled cycles stretch the dwell; they do not count.
- Simultaneous events:
  - rst wins over en, mode and sel.
  - A mode change on the same edge as a scan wrap: the new mode governs that edge.
- Reset mid-scan: the next edge after rst deasserts resumes from ch=0, cnt=0, MANUAL.

## Test plan
1. Reset: N=4, WIDTH=4, d={4'hD,4'hC,4'hB,4'hA} (ch3..ch0); hold rst for 2 edges with arbitrary inputs -> o=0, ch=0, ch_stb=0. Then mode=0, sel=2 -> next edge: o=4'hC, ch=2, ch_stb=1 for one cycle.
2. Manual hold and invalid select: N=3, sel=1 -> ch=1, then sel=3 -> ch stays 1, ch_stb=0. Change d[1] -> o follows after 1 cycle.
3. Scan wrap: N=4, DWELL=3, start ch=2, mode=1 -> ch sequence per edge: 2,2,2,3,3,3,0,0,0,1. ch_stb high only on the cycles after the 2->3, 3->0 and 0->1 changes; o matches d[ch] each cycle.
4. Enable freeze: in scan with cnt=1, drop en for 5 cycles while toggling d -> o, ch, cnt are unchanged and ch_stb=0. On re-enable, ch advances after exactly 1 more enabled edge.
5. Mode switch: scanning at ch=3, set mode=0, sel=1 -> next edge ch=1, ch_stb=1. Set mode=1 -> ch stays 1 for DWELL edges, then becomes 2.
6. Reset mid-scan: assert rst while ch=2, cnt=2 -> after that edge, o=0, ch=0, cnt=0, and the block is in manual mode.

Source files
------------

// File: rtl/muxn_scan.sv
// N-channel registered multiplexer with manual select and an automatic scan mode
// that rotates through the channels, dwelling DWELL enabled cycles on each.
module muxn_scan #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int DWELL = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 en,
  output logic [WIDTH-1:0]     o,
  output logic [SELW-1:0]      ch,
  output logic                 ch_stb
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_MAX  = SELW'(N - 1);
  localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} mode_t;

  mode_t             mode_p0;
  logic [SELW-1:0]   ch_p0;
  logic [CNTW-1:0]   cnt_p0;
  logic [WIDTH-1:0]  o_p0;
  logic              stb_p0;

  logic [SELW-1:0]   ch_next;
  logic [CNTW-1:0]   cnt_next;
  logic [CNTW-1:0]   cnt_cur;

  // Power-of-two sized view of d; unpopulated slots read as zero.
  logic [WIDTH-1:0]  dch [2**SELW];

  for (genvar i = 0; i < 2**SELW; i++) begin : g_dch
    if (i < N) begin : g_real
      assign dch[i] = d[i*WIDTH +: WIDTH];
    end else begin : g_pad
      assign dch[i] = '0;
    end
  end

  always_comb begin
    ch_next  = ch_p0;
    cnt_next = '0;
    // Entering scan from manual restarts the dwell count at zero.
    cnt_cur  = (mode_p0 == SCAN) ? cnt_p0 : '0;
    if (mode) begin
      if (cnt_cur == CNT_MAX) begin
        ch_next  = (ch_p0 == CH_MAX) ? '0 : ch_p0 + SELW'(1);
        cnt_next = '0;
      end else begin
        cnt_next = cnt_cur + CNTW'(1);
      end
    end else if ({1'b0, sel} < N_EXT) begin
      ch_next = sel;
    end
  end

  // Stage p0: registered channel, data and change strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_p0 <= MANUAL;
      ch_p0   <= '0;
      cnt_p0  <= '0;
      o_p0    <= '0;
      stb_p0  <= 1'b0;
    end else if (en) begin
      mode_p0 <= mode_t'(mode);
      ch_p0   <= ch_next;
      cnt_p0  <= cnt_next;
      o_p0    <= dch[ch_next];
      stb_p0  <= (ch_next != ch_p0);
    end else begin
      stb_p0  <= 1'b0;
    end
  end

  assign o      = o_p0;
  assign ch     = ch_p0;
  assign ch_stb = stb_p0;

endmodule

// File: tb/tb_muxn_scan.sv
// Directed bench for muxn_scan: a 4-channel DWELL=3 instance and a
// 3-channel DWELL=1 instance sharing clock and reset.
module tb_muxn_scan;

  logic        clk;
  logic        rst;

  logic [15:0] da;
  logic [1:0]  sela;
  logic        modea, ena;
  logic [3:0]  oa;
  logic [1:0]  cha;
  logic        stba;

  logic [11:0] db;
  logic [1:0]  selb;
  logic        modeb, enb;
  logic [3:0]  ob;
  logic [1:0]  chb;
  logic        stbb;

  int n_chk  = 0;
  int n_pass = 0;

  muxn_scan #(.WIDTH(4), .N(4), .DWELL(3)) u_a (
    .clk(clk), .rst(rst), .d(da), .sel(sela), .mode(modea), .en(ena),
    .o(oa), .ch(cha), .ch_stb(stba)
  );

  muxn_scan #(.WIDTH(4), .N(3), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .d(db), .sel(selb), .mode(modeb), .en(enb),
    .o(ob), .ch(chb), .ch_stb(stbb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] eo, input logic [1:0] ech,
                       input logic estb);
    chk({tag, ".o"},   {12'h0, oa},   {12'h0, eo});
    chk({tag, ".ch"},  {14'h0, cha},  {14'h0, ech});
    chk({tag, ".stb"}, {15'h0, stba}, {15'h0, estb});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] eo, input logic [1:0] ech,
                       input logic estb);
    chk({tag, ".o"},   {12'h0, ob},   {12'h0, eo});
    chk({tag, ".ch"},  {14'h0, chb},  {14'h0, ech});
    chk({tag, ".stb"}, {15'h0, stbb}, {15'h0, estb});
  endtask

  // Scan from ch=2 with DWELL=3, values after each of nine edges.
  logic [1:0] scan_ch  [9];
  logic       scan_stb [9];
  logic [3:0] scan_o   [9];

  initial begin
    scan_ch  = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    scan_stb = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    scan_o   = '{4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hA, 4'hA, 4'hA, 4'hB};

    rst = 1'b1;
    da = 16'hDCBA; sela = 2'd3; modea = 1'b1; ena = 1'b1;
    db = 12'h765;  selb = 2'd2; modeb = 1'b1; enb = 1'b1;
    step();
    step();
    chk_a("rst_a", 4'h0, 2'd0, 1'b0);
    chk_b("rst_b", 4'h0, 2'd0, 1'b0);

    rst = 1'b0; enb = 1'b0;
    modea = 1'b0; sela = 2'd2;
    step();
    chk_a("man_sel2", 4'hC, 2'd2, 1'b1);
    step();
    chk_a("man_hold", 4'hC, 2'd2, 1'b0);

    modea = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_a($sformatf("scan%0d", i), scan_o[i], scan_ch[i], scan_stb[i]);
    end

    // ch=1, cnt=0: one edge brings cnt to 1, then freeze with d toggling.
    step();
    chk_a("pre_frz", 4'hB, 2'd1, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      da = da ^ 16'h5A5A ^ 16'(i);
      step();
      chk_a($sformatf("frz%0d", i), 4'hB, 2'd1, 1'b0);
    end
    da = 16'hDCBA; ena = 1'b1;
    step();
    chk_a("unfrz0", 4'hB, 2'd1, 1'b0);
    step();
    chk_a("unfrz1", 4'hC, 2'd2, 1'b1);

    step();
    step();
    step();
    chk_a("at_ch3", 4'hD, 2'd3, 1'b1);
    modea = 1'b0; sela = 2'd1;
    step();
    chk_a("to_man", 4'hB, 2'd1, 1'b1);
    modea = 1'b1; sela = 2'd3;
    step();
    chk_a("rescan0", 4'hB, 2'd1, 1'b0);
    step();
    chk_a("rescan1", 4'hB, 2'd1, 1'b0);
    step();
    chk_a("rescan2", 4'hC, 2'd2, 1'b1);

    // Now ch=2, cnt=0; two edges bring cnt to 2, then reset with en low.
    step();
    step();
    chk_a("pre_rst", 4'hC, 2'd2, 1'b0);
    rst = 1'b1; ena = 1'b0;
    step();
    chk_a("mid_rst", 4'h0, 2'd0, 1'b0);
    rst = 1'b0; ena = 1'b1;
    step();
    chk_a("post_rst0", 4'hA, 2'd0, 1'b0);
    step();
    chk_a("post_rst1", 4'hA, 2'd0, 1'b0);
    step();
    chk_a("post_rst2", 4'hB, 2'd1, 1'b1);
    modea = 1'b0; sela = 2'd3;
    step();
    chk_a("post_man", 4'hD, 2'd3, 1'b1);

    // Three-channel instance: invalid select, data follow, DWELL=1 wrap.
    ena = 1'b0;
    enb = 1'b1; modeb = 1'b0; selb = 2'd1;
    step();
    chk_b("b_sel1", 4'h6, 2'd1, 1'b1);
    selb = 2'd3;
    step();
    chk_b("b_sel3", 4'h6, 2'd1, 1'b0);
    db = 12'h795;
    step();
    chk_b("b_dchg", 4'h9, 2'd1, 1'b0);
    modeb = 1'b1;
    step();
    chk_b("b_scan0", 4'h7, 2'd2, 1'b1);
    step();
    chk_b("b_scan1", 4'h5, 2'd0, 1'b1);
    step();
    chk_b("b_scan2", 4'h9, 2'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
